// File: rtl/pc_seq_pkg.sv
// Shared types, widths and constants for the program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned IDX_W = 26;

  localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [PC_W-1:0] TRAP_VECTOR_DEF  = 32'h0000_0080;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_e;

  // J-type target: region nibble of pc+4, instruction index, word alignment.
  function automatic logic [PC_W-1:0] jump_target(input logic [3:0]       region,
                                                   input logic [IDX_W-1:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake plus control-unit redirect inputs for the PC sequencer.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic             fetch_valid;
  logic             fetch_ready;
  logic [PC_W-1:0]  pc_out;
  logic [PC_W-1:0]  pc_plus4;
  logic             stall;
  logic             branch_taken;
  logic [PC_W-1:0]  branch_offset;
  logic             jump;
  logic [IDX_W-1:0] jump_index;
  logic             jr;
  logic [PC_W-1:0]  jr_target;
  logic             halt;
  logic             halted;
  logic             redirect_pend;
  logic             trap;

  // Sequencer side
  modport master (
    output fetch_valid, pc_out, pc_plus4, halted, redirect_pend, trap,
    input  fetch_ready, stall, branch_taken, branch_offset, jump, jump_index,
           jr, jr_target, halt
  );

  // Control unit / instruction memory side
  modport slave (
    input  fetch_valid, pc_out, pc_plus4, halted, redirect_pend, trap,
    output fetch_ready, stall, branch_taken, branch_offset, jump, jump_index,
           jr, jr_target, halt
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC datapath: pc+4, branch adder, jump concat, priority mux.
module pc_target_calc
  import pc_seq_pkg::*;
(
  input  logic [PC_W-1:0]  pc_i,
  input  logic             branch_taken_i,
  input  logic [PC_W-1:0]  branch_offset_i,
  input  logic             jump_i,
  input  logic [IDX_W-1:0] jump_index_i,
  input  logic             jr_i,
  input  logic [PC_W-1:0]  jr_target_i,
  output logic [PC_W-1:0]  pc_plus4_o,
  output logic [PC_W-1:0]  next_pc_o
);

  logic [PC_W-1:0] branch_pc;

  assign pc_plus4_o = pc_i + PC_W'(4);
  assign branch_pc  = pc_plus4_o + (branch_offset_i << 2);

  // Priority select: jr > jump > branch > sequential
  always_comb begin
    next_pc_o = pc_plus4_o;
    if (jr_i) begin
      next_pc_o = jr_target_i & ~PC_W'(3);
    end else if (jump_i) begin
      next_pc_o = jump_target(pc_plus4_o[PC_W-1:PC_W-4], jump_index_i);
    end else if (branch_taken_i) begin
      next_pc_o = branch_pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, fetch handshake FSM and stall-buffered redirect.
// Optional build macro: PC_MISALIGN_TRAP_EN (misaligned jr -> TRAP_VECTOR + trap pulse).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
`ifdef PC_MISALIGN_TRAP_EN
  ,
  parameter logic [PC_W-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
`endif
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            redirect_pend_q, redirect_pend_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] calc_next_pc;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] pc_plus4;
  logic            accept;

  assign accept = fetch_valid_q & bus.fetch_ready;

  pc_target_calc u_calc (
    .pc_i            (pc_q),
    .branch_taken_i  (bus.branch_taken),
    .branch_offset_i (bus.branch_offset),
    .jump_i          (bus.jump),
    .jump_index_i    (bus.jump_index),
    .jr_i            (bus.jr),
    .jr_target_i     (bus.jr_target),
    .pc_plus4_o      (pc_plus4),
    .next_pc_o       (calc_next_pc)
  );

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_sel;
  logic pend_trap_q, pend_trap_d;
  logic trap_q, trap_d;

  // jr is top priority, so a misaligned jr target always wins the mux
  assign trap_sel = bus.jr & (bus.jr_target[1:0] != 2'b00);
  assign next_pc  = trap_sel ? TRAP_VECTOR : calc_next_pc;
`else
  assign next_pc  = calc_next_pc;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // Next-state: halt beats stall; stall/redirects only count on accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:  state_d = RUN;
      RUN: begin
        if (accept) begin
          if (bus.halt)       state_d = HALT;
          else if (bus.stall) state_d = STALL;
        end
      end
      STALL: if (!bus.stall) state_d = RUN;
      HALT:  state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    pc_d            = pc_q;
    pend_d          = pend_q;
    redirect_pend_d = redirect_pend_q;
    fetch_valid_d   = (state_d == RUN);
    halted_d        = (state_d == HALT);
`ifdef PC_MISALIGN_TRAP_EN
    pend_trap_d     = pend_trap_q;
    trap_d          = 1'b0;
`endif
    case (state_q)
      RUN: begin
        if (accept && !bus.halt) begin
          if (bus.stall) begin
            pend_d          = next_pc;
            redirect_pend_d = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            pend_trap_d     = trap_sel;
`endif
          end else begin
            pc_d = next_pc;
`ifdef PC_MISALIGN_TRAP_EN
            trap_d = trap_sel;
`endif
          end
        end
      end
      STALL: begin
        if (!bus.stall) begin
          pc_d            = pend_q;
          redirect_pend_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
          trap_d          = pend_trap_q;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_VECTOR;
      pend_q          <= '0;
      fetch_valid_q   <= 1'b0;
      redirect_pend_q <= 1'b0;
      halted_q        <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      pend_trap_q     <= 1'b0;
      trap_q          <= 1'b0;
`endif
    end else begin
      pc_q            <= pc_d;
      pend_q          <= pend_d;
      fetch_valid_q   <= fetch_valid_d;
      redirect_pend_q <= redirect_pend_d;
      halted_q        <= halted_d;
`ifdef PC_MISALIGN_TRAP_EN
      pend_trap_q     <= pend_trap_d;
      trap_q          <= trap_d;
`endif
    end
  end

  assign bus.fetch_valid   = fetch_valid_q;
  assign bus.pc_out        = pc_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.halted        = halted_q;
  assign bus.redirect_pend = redirect_pend_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.trap          = trap_q;
`else
  assign bus.trap          = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer; expected PCs queued on stimulus, compared on output.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic clk;
  logic rst;
  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        exp_trap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fetch_ready   = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 32'h0;
    bus.jump          = 1'b0;
    bus.jump_index    = 26'h0;
    bus.jr            = 1'b0;
    bus.jr_target     = 32'h0;
    bus.halt          = 1'b0;
  endtask

  // One accepted request with the given redirect inputs, then inputs released
  task automatic accept_cycle(input logic jr_v, input logic [31:0] jr_t,
                              input logic j_v, input logic [25:0] j_idx,
                              input logic b_v, input logic [31:0] b_off,
                              input logic hl);
    bus.jr = jr_v; bus.jr_target = jr_t;
    bus.jump = j_v; bus.jump_index = j_idx;
    bus.branch_taken = b_v; bus.branch_offset = b_off;
    bus.halt = hl; bus.fetch_ready = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.fetch_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", bus.fetch_valid); end
      checks++;
      if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", bus.pc_out); end
    end
    checks++;
    if (bus.redirect_pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", bus.redirect_pend); end
    checks++;
    if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    checks++;
    if (bus.trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b want 0", bus.trap); end
    rst = 1'b0;
    checks++;
    if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_fv: got %b want 0", bus.fetch_valid); end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'(i * 4));
      tick();
      exp_pc = exp_q.pop_front();
      checks++;
      if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL boot_seq: got %h want %h", bus.pc_out, exp_pc); end
      checks++;
      if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL run_fv: got %b want 1", bus.fetch_valid); end
    end
    bus.fetch_ready = 1'b0;
  endtask

  task automatic test_branch();
    exp_q.push_back(32'h0000_0100);
    accept_cycle(1'b0, 32'h0, 1'b1, 26'h40, 1'b0, 32'h0, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL branch_setup: got %h want %h", bus.pc_out, exp_pc); end
    exp_q.push_back(32'h0000_00FC);
    accept_cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL branch_neg: got %h want %h", bus.pc_out, exp_pc); end
    exp_q.push_back(32'h0000_0100);
    accept_cycle(1'b0, 32'h0, 1'b1, 26'h40, 1'b0, 32'h0, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL branch_setup2: got %h want %h", bus.pc_out, exp_pc); end
    exp_q.push_back(32'h0000_0144);
    accept_cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0010, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL branch_pos: got %h want %h", bus.pc_out, exp_pc); end
  endtask

  task automatic test_priority();
    exp_q.push_back(32'h1000_0000);
    accept_cycle(1'b1, 32'h1000_0000, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL prio_setup: got %h want %h", bus.pc_out, exp_pc); end
    exp_q.push_back(32'h0000_2000);
    accept_cycle(1'b1, 32'h0000_2000, 1'b1, 26'h3, 1'b1, 32'h5, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL prio_jr: got %h want %h", bus.pc_out, exp_pc); end
    exp_q.push_back(32'h0000_0100);
    accept_cycle(1'b0, 32'h0, 1'b1, 26'h40, 1'b1, 32'h7, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL prio_jump: got %h want %h", bus.pc_out, exp_pc); end
    exp_q.push_back(32'h2000_0000);
    accept_cycle(1'b1, 32'h2000_0000, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL nibble_setup: got %h want %h", bus.pc_out, exp_pc); end
    exp_q.push_back(32'h2000_0100);
    accept_cycle(1'b0, 32'h0, 1'b1, 26'h40, 1'b0, 32'h0, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL jump_nibble: got %h want %h", bus.pc_out, exp_pc); end
  endtask

  task automatic test_stall();
    exp_q.push_back(32'h0);
    accept_cycle(1'b1, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL stall_setup: got %h want %h", bus.pc_out, exp_pc); end
    exp_q.push_back(32'h0000_0040);
    bus.branch_taken = 1'b1; bus.branch_offset = 32'hF; bus.stall = 1'b1; bus.fetch_ready = 1'b1;
    tick();
    bus.branch_taken = 1'b0; bus.branch_offset = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL stall_hold: cycle %0d got %h want 00000000", i, bus.pc_out); end
      checks++;
      if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_fv: cycle %0d got %b want 0", i, bus.fetch_valid); end
      checks++;
      if (bus.redirect_pend !== 1'b1) begin errors++; $display("FAIL stall_pend: cycle %0d got %b want 1", i, bus.redirect_pend); end
      bus.jump = (i == 0); bus.jump_index = 26'h123;
      if (i == 2) bus.stall = 1'b0;
      tick();
    end
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL stall_release: got %h want %h", bus.pc_out, exp_pc); end
    checks++;
    if (bus.redirect_pend !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b want 0", bus.redirect_pend); end
    checks++;
    if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL stall_resume: got %b want 1", bus.fetch_valid); end
    clear_inputs();
  endtask

  task automatic test_wrap_handshake();
    exp_q.push_back(32'hFFFF_FFFC);
    accept_cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL wrap_setup: got %h want %h", bus.pc_out, exp_pc); end
    exp_q.push_back(32'h0);
    accept_cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL wrap: got %h want %h", bus.pc_out, exp_pc); end
    bus.fetch_ready = 1'b0; bus.jump = 1'b1; bus.jump_index = 26'h5; bus.branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL hold_pc: cycle %0d got %h want 00000000", i, bus.pc_out); end
      checks++;
      if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL hold_fv: cycle %0d got %b want 1", i, bus.fetch_valid); end
    end
    clear_inputs();
  endtask

  task automatic test_halt();
    accept_cycle(1'b0, 32'h0, 1'b1, 26'h55, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_flag: cycle %0d got %b want 1", i, bus.halted); end
      checks++;
      if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL halt_pc: cycle %0d got %h want 00000000", i, bus.pc_out); end
      checks++;
      if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_fv: cycle %0d got %b want 0", i, bus.fetch_valid); end
      bus.fetch_ready = 1'b1; bus.jr = 1'b1; bus.jr_target = 32'h300;
      tick();
    end
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_rst: got %b want 0", bus.halted); end
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL halt_rerun: got %b want 1", bus.fetch_valid); end
  endtask

  task automatic test_misalign();
`ifdef PC_MISALIGN_TRAP_EN
    exp_trap = 1'b1;
    exp_q.push_back(32'h0000_0080);
`else
    exp_trap = 1'b0;
    exp_q.push_back(32'h0000_2000);
`endif
    accept_cycle(1'b1, 32'h0000_2002, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL misalign_pc: got %h want %h", bus.pc_out, exp_pc); end
    checks++;
    if (bus.trap !== exp_trap) begin errors++; $display("FAIL misalign_trap: got %b want %b", bus.trap, exp_trap); end
    tick();
    checks++;
    if (bus.trap !== 1'b0) begin errors++; $display("FAIL trap_pulse: got %b want 0", bus.trap); end
    // Misaligned jr buffered across a stall
    exp_q.push_back(exp_trap ? 32'h0000_0080 : 32'h0000_2000);
    bus.jr = 1'b1; bus.jr_target = 32'h0000_2003; bus.stall = 1'b1; bus.fetch_ready = 1'b1;
    tick();
    bus.jr = 1'b0; bus.jr_target = 32'h0;
    checks++;
    if (bus.trap !== 1'b0) begin errors++; $display("FAIL trap_in_stall: got %b want 0", bus.trap); end
    bus.stall = 1'b0;
    tick();
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL stall_misalign_pc: got %h want %h", bus.pc_out, exp_pc); end
    checks++;
    if (bus.trap !== exp_trap) begin errors++; $display("FAIL stall_misalign_trap: got %b want %b", bus.trap, exp_trap); end
    clear_inputs();
    tick();
    checks++;
    if (bus.trap !== 1'b0) begin errors++; $display("FAIL stall_trap_pulse: got %b want 0", bus.trap); end
  endtask

  task automatic test_reset_in_stall();
    bus.branch_taken = 1'b1; bus.branch_offset = 32'h3; bus.stall = 1'b1; bus.fetch_ready = 1'b1;
    tick();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.redirect_pend !== 1'b1) begin errors++; $display("FAIL rst_stall_pend: got %b want 1", bus.redirect_pend); end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.pc_out !== RESET_VECTOR_DEF) begin errors++; $display("FAIL rst_stall_pc: got %h want %h", bus.pc_out, RESET_VECTOR_DEF); end
    checks++;
    if (bus.redirect_pend !== 1'b0) begin errors++; $display("FAIL rst_stall_clear: got %b want 0", bus.redirect_pend); end
    checks++;
    if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_fv: got %b want 0", bus.fetch_valid); end
    rst = 1'b0; bus.stall = 1'b0; bus.fetch_ready = 1'b0;
    tick();
    checks++;
    if (bus.pc_out !== RESET_VECTOR_DEF) begin errors++; $display("FAIL rst_stall_discard: got %h want %h", bus.pc_out, RESET_VECTOR_DEF); end
    checks++;
    if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL rst_stall_run: got %b want 1", bus.fetch_valid); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] mpc;
    logic [31:0] p4;
    logic [31:0] off;
    logic [31:0] tgt;
    logic [25:0] idx;
    int          sel;
    mpc = bus.pc_out === 32'h0 ? 32'h0 : 32'h0;
    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 3));
      off = 32'($signed($urandom_range(0, 200)) - 100);
      idx = 26'($urandom);
      tgt = $urandom;
      p4  = mpc + 32'd4;
      clear_inputs();
      bus.fetch_ready = 1'b1;
      case (sel)
        1: begin bus.branch_taken = 1'b1; bus.branch_offset = off; mpc = p4 + (off << 2); end
        2: begin bus.jump = 1'b1; bus.jump_index = idx; mpc = {p4[31:28], idx, 2'b00}; end
        3: begin
          bus.jr = 1'b1; bus.jr_target = tgt; mpc = {tgt[31:2], 2'b00};
`ifdef PC_MISALIGN_TRAP_EN
          if (tgt[1:0] != 2'b00) mpc = 32'h0000_0080;
`endif
        end
        default: mpc = p4;
      endcase
      exp_q.push_back(mpc);
      tick();
      exp_pc = exp_q.pop_front(); checks++;
      if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL b2b: step %0d sel %0d got %h want %h", i, sel, bus.pc_out, exp_pc); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_priority();
    test_stall();
    test_wrap_handshake();
    test_halt();
    test_misalign();
    test_reset_in_stall();
    // Return to a known PC before the randomized run
    rst = 1'b1; tick(); rst = 1'b0; tick();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
